// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
package disp_pkg;

    localparam int unsigned DEF_NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {S_BLANK, S_SHOW} scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Data inputs from the preview selector and the registered display drive outputs.
interface display_scan_ctrl_if #(
    parameter int unsigned NUM_DIGITS = disp_pkg::DEF_NUM_DIGITS
);

    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   en_n;
    logic [NUM_DIGITS-1:0]   dp_in_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    frame_done;

    modport master (
        output digits, en_n, dp_in_n,
        input  an_n, seg_n, dp_n, frame_done
    );

    modport slave (
        input  digits, en_n, dp_in_n,
        output an_n, seg_n, dp_n, frame_done
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[hex];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode display scanner with per-slot dead time
// and a once-per-frame input snapshot.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned REFRESH_DIV  = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    display_scan_ctrl_if.slave   bus
);

    localparam int unsigned SLOT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    scan_state_t             state_q, state_d;

    logic [4*NUM_DIGITS-1:0] snap_digits_q;
    logic [NUM_DIGITS-1:0]   snap_en_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    slot_wrap;
    logic                    frame_start;
    logic                    frame_end;
    logic [3:0]              nibble;
    logic [6:0]              nibble_seg;

    always_comb begin
        slot_wrap   = (slot_q == SLOT_LAST);
        frame_start = (slot_q == '0) && (idx_q == '0);
        frame_end   = slot_wrap && (idx_q == IDX_LAST);
        slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d       = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Slot phase tracks the counter value it will hold after this edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BLANK: if (32'(slot_d) >= BLANK_CYCLES) state_d = S_SHOW;
            S_SHOW:  if (32'(slot_d) < BLANK_CYCLES)  state_d = S_BLANK;
            default: state_d = S_BLANK;
        endcase
    end

    assign nibble = snap_digits_q[{idx_q, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .hex   (nibble),
        .seg_n (nibble_seg)
    );

    // Disabled digits still consume their slot so brightness is independent of the mask.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        fd_d  = frame_end;
        if ((state_q == S_SHOW) && !snap_en_q[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = nibble_seg;
            dp_d        = snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q  <= '0;
            idx_q   <= '0;
            state_q <= (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_digits_q <= '0;
            snap_en_q     <= '1;
            snap_dp_q     <= '1;
        end else if (frame_start) begin
            snap_digits_q <= bus.digits;
            snap_en_q     <= bus.en_n;
            snap_dp_q     <= bus.dp_in_n;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= fd_d;
        end
    end

    assign bus.an_n       = an_q;
    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a slot-position reference model.
module tb_display_scan_ctrl;

    localparam int RD  = 8;
    localparam int BLK = 2;
    localparam int ND  = 8;
    localparam int FRAME = RD * ND;

    localparam logic [6:0] TB_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk;
    logic reset_n;

    int checks;
    int failures;

    // Reference model: position since reset release plus the frame snapshot.
    int          p;
    int          exp_pos;
    logic [31:0] m_digits;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;

    display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Anode invariants: at most one low bit, and a dead gap between different digits.
    logic [7:0] last_low;
    int         blank_run;
    always @(negedge clk) begin
        if (!reset_n) begin
            last_low  <= 8'hFF;
            blank_run <= 0;
        end else begin
            checks++;
            if ($countones(~bus.an_n) > 1) begin
                failures++;
                $display("FAIL anode_onehot an_n=%h required at most one low bit", bus.an_n);
            end
            if (bus.an_n == 8'hFF) begin
                blank_run <= blank_run + 1;
            end else begin
                if (last_low != 8'hFF && bus.an_n != last_low) begin
                    checks++;
                    if (blank_run < BLK) begin
                        failures++;
                        $display("FAIL anode_gap blank=%0d required>=%0d (%h->%h)",
                                 blank_run, BLK, last_low, bus.an_n);
                    end
                end
                last_low  <= bus.an_n;
                blank_run <= 0;
            end
        end
    end

    task automatic model_reset();
        p        = 0;
        m_digits = 32'h0;
        m_en     = 8'hFF;
        m_dp     = 8'hFF;
    endtask

    // One clock: derive expected outputs for this edge, then sample the snapshot.
    task automatic step();
        int slot;
        int idx;
        @(posedge clk);
        exp_pos = p;
        slot    = p % RD;
        idx     = (p / RD) % ND;
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        exp_fd  = ((p % FRAME) == FRAME - 1);
        if (slot >= BLK && m_en[idx] == 1'b0) begin
            exp_an  = ~(8'h01 << idx);
            exp_seg = TB_SEG[m_digits[idx*4 +: 4]];
            exp_dp  = m_dp[idx];
        end
        if ((p % FRAME) == 0) begin
            m_digits = bus.digits;
            m_en     = bus.en_n;
            m_dp     = bus.dp_in_n;
        end
        p++;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.digits   = $urandom();
        bus.en_n     = 8'($urandom());
        bus.dp_in_n  = 8'($urandom());
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.an_n !== 8'hFF) begin failures++;
            $display("FAIL reset_an an_n=%h required=ff", bus.an_n); end
        checks++; if (bus.seg_n !== 7'h7F) begin failures++;
            $display("FAIL reset_seg seg_n=%b required=1111111", bus.seg_n); end
        checks++; if (bus.dp_n !== 1'b1) begin failures++;
            $display("FAIL reset_dp dp_n=%b required=1", bus.dp_n); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++;
            $display("FAIL reset_fd frame_done=%b required=0", bus.frame_done); end
        @(negedge clk);
        reset_n  = 1'b1;
        model_reset();
        bus.en_n = 8'h00;
        repeat (4) step();
        checks++; if (bus.an_n !== 8'hFE) begin failures++;
            $display("FAIL pre_reset_show an_n=%h required=fe", bus.an_n); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.an_n !== 8'hFF || bus.seg_n !== 7'h7F || bus.dp_n !== 1'b1 ||
                      bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset an=%h seg=%b dp=%b fd=%b required ff/1111111/1/0",
                     bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done);
        end
    endtask

    task automatic test_full_scan();
        int fd_count;
        do_reset();
        bus.digits  = 32'h1234_ABCD;
        bus.en_n    = 8'h00;
        bus.dp_in_n = 8'hFF;
        fd_count    = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks++;
            if (bus.an_n !== exp_an || bus.seg_n !== exp_seg || bus.dp_n !== exp_dp ||
                bus.frame_done !== exp_fd) begin
                failures++;
                $display("FAIL scan_model pos=%0d an=%h/%h seg=%b/%b dp=%b/%b fd=%b/%b", exp_pos,
                         bus.an_n, exp_an, bus.seg_n, exp_seg, bus.dp_n, exp_dp,
                         bus.frame_done, exp_fd);
            end
            if (bus.frame_done === 1'b1) fd_count++;
            if ((exp_pos % FRAME) < BLK) begin
                checks++; if (bus.an_n !== 8'hFF) begin failures++;
                    $display("FAIL slot0_blank pos=%0d an_n=%h required=ff", exp_pos, bus.an_n); end
            end else if ((exp_pos % FRAME) < RD) begin
                checks++; if (bus.an_n !== 8'hFE || bus.seg_n !== 7'b0100001) begin failures++;
                    $display("FAIL slot0_show pos=%0d an=%h seg=%b required fe/0100001",
                             exp_pos, bus.an_n, bus.seg_n); end
            end else if ((exp_pos % FRAME) >= FRAME - RD + BLK) begin
                checks++; if (bus.an_n !== 8'h7F || bus.seg_n !== 7'b1111001) begin failures++;
                    $display("FAIL slot7_show pos=%0d an=%h seg=%b required 7f/1111001",
                             exp_pos, bus.an_n, bus.seg_n); end
            end
        end
        checks++; if (fd_count !== 2) begin failures++;
            $display("FAIL frame_done_count count=%0d required=2", fd_count); end
    endtask

    task automatic test_partial_enable();
        do_reset();
        bus.digits  = ($urandom() & 32'hFFFF_FF00) | 32'h0000_0042;
        bus.en_n    = 8'b1111_1100;
        bus.dp_in_n = 8'($urandom());
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            checks++;
            if (bus.an_n !== exp_an || bus.seg_n !== exp_seg || bus.dp_n !== exp_dp ||
                bus.frame_done !== exp_fd) begin
                failures++;
                $display("FAIL partial_model pos=%0d an=%h/%h seg=%b/%b dp=%b/%b fd=%b/%b",
                         exp_pos, bus.an_n, exp_an, bus.seg_n, exp_seg, bus.dp_n, exp_dp,
                         bus.frame_done, exp_fd);
            end
            checks++;
            if (!(bus.an_n === 8'hFF || (bus.an_n === 8'hFE && bus.seg_n === 7'b0100100) ||
                  (bus.an_n === 8'hFD && bus.seg_n === 7'b0011001))) begin
                failures++;
                $display("FAIL partial_pattern pos=%0d an=%h seg=%b required ff|fe:2|fd:4",
                         exp_pos, bus.an_n, bus.seg_n);
            end
            if ((exp_pos / RD) % ND >= 2) begin
                checks++; if (bus.an_n !== 8'hFF) begin failures++;
                    $display("FAIL partial_off pos=%0d an_n=%h required=ff", exp_pos, bus.an_n); end
            end
        end
    endtask

    task automatic test_snapshot();
        do_reset();
        bus.digits  = 32'h0;
        bus.en_n    = 8'h00;
        bus.dp_in_n = 8'hFF;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (exp_pos == 3 * RD + 3) bus.digits = 32'hFFFF_FFFF;
            checks++;
            if (bus.an_n !== exp_an || bus.seg_n !== exp_seg || bus.dp_n !== exp_dp ||
                bus.frame_done !== exp_fd) begin
                failures++;
                $display("FAIL snap_model pos=%0d an=%h/%h seg=%b/%b dp=%b/%b fd=%b/%b", exp_pos,
                         bus.an_n, exp_an, bus.seg_n, exp_seg, bus.dp_n, exp_dp,
                         bus.frame_done, exp_fd);
            end
            if (bus.an_n !== 8'hFF) begin
                checks++;
                if (bus.seg_n !== ((exp_pos < FRAME) ? 7'b1000000 : 7'b0001110)) begin
                    failures++;
                    $display("FAIL snap_tear pos=%0d seg=%b required=%b", exp_pos, bus.seg_n,
                             (exp_pos < FRAME) ? 7'b1000000 : 7'b0001110);
                end
            end
        end
    endtask

    task automatic test_dp_decode();
        logic [15:0] seen;
        logic [31:0] frame_digits [2];
        int          idx;
        logic [3:0]  val;
        logic        req_dp;
        frame_digits[0] = 32'h7654_3210;
        frame_digits[1] = 32'hFEDC_BA98;
        seen = '0;
        do_reset();
        bus.digits  = frame_digits[0];
        bus.en_n    = 8'h00;
        bus.dp_in_n = 8'hFE;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (exp_pos == FRAME - 1) bus.digits = frame_digits[1];
            checks++;
            if (bus.an_n !== exp_an || bus.seg_n !== exp_seg || bus.dp_n !== exp_dp ||
                bus.frame_done !== exp_fd) begin
                failures++;
                $display("FAIL dec_model pos=%0d an=%h/%h seg=%b/%b dp=%b/%b fd=%b/%b", exp_pos,
                         bus.an_n, exp_an, bus.seg_n, exp_seg, bus.dp_n, exp_dp,
                         bus.frame_done, exp_fd);
            end
            idx    = (exp_pos / RD) % ND;
            req_dp = !((exp_pos % RD) >= BLK && idx == 0);
            checks++; if (bus.dp_n !== req_dp) begin failures++;
                $display("FAIL dp_digit0 pos=%0d dp_n=%b required=%b", exp_pos, bus.dp_n, req_dp); end
            if ((exp_pos % RD) >= BLK) begin
                val = frame_digits[exp_pos / FRAME][idx*4 +: 4];
                if (bus.seg_n === TB_SEG[val]) seen[val] = 1'b1;
            end
        end
        checks++; if (seen !== 16'hFFFF) begin failures++;
            $display("FAIL decode_sweep seen=%h required=ffff", seen); end
    endtask

    task automatic test_random();
        int reset_at;
        do_reset();
        bus.digits  = $urandom();
        bus.en_n    = 8'($urandom());
        bus.dp_in_n = 8'($urandom());
        reset_at    = $urandom_range(2 * FRAME, 3 * FRAME);
        for (int c = 0; c < 6 * FRAME; c++) begin
            if (c == reset_at) do_reset();
            step();
            if ($urandom_range(0, 3) == 0) begin
                bus.digits  = $urandom();
                bus.en_n    = 8'($urandom());
                bus.dp_in_n = 8'($urandom());
            end
            checks++;
            if (bus.an_n !== exp_an || bus.seg_n !== exp_seg || bus.dp_n !== exp_dp ||
                bus.frame_done !== exp_fd) begin
                failures++;
                $display("FAIL rand_model pos=%0d an=%h/%h seg=%b/%b dp=%b/%b fd=%b/%b", exp_pos,
                         bus.an_n, exp_an, bus.seg_n, exp_seg, bus.dp_n, exp_dp,
                         bus.frame_done, exp_fd);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        model_reset();
        test_reset();
        test_full_scan();
        test_partial_enable();
        test_snapshot();
        test_dp_decode();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
